// File: rtl/alu_seq_if.sv
// Operand/result bus and BEGIN/END handshake for the sequential ALU.
interface alu_seq_if;
    logic       BEGIN;
    logic [1:0] op_code;
    logic [7:0] inbus;
    logic [7:0] outbus;
    logic       END;

    modport master (output BEGIN, op_code, inbus, input outbus, END);
    modport slave  (input BEGIN, op_code, inbus, output outbus, END);
endinterface

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU: add, sub, Booth radix-2 signed multiply and restoring
// unsigned divide over a shared 8-bit bus, driven by a one-hot FSM.
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus,
    output logic [16:0] act_state_debug,
    output logic [16:0] next_state_debug,
    output logic [8:0]  A_reg_debug,
    output logic [8:0]  Q_reg_debug,
    output logic [8:0]  M_reg_debug
);
    typedef enum logic [16:0] {
        IDLE        = 17'h00001,
        LOAD_B      = 17'h00002,
        ADD         = 17'h00004,
        SUB         = 17'h00008,
        MUL_TEST    = 17'h00010,
        MUL_ADD     = 17'h00020,
        MUL_SUB     = 17'h00040,
        MUL_SHIFT   = 17'h00080,
        MUL_CHECK   = 17'h00100,
        DIV_SHIFT   = 17'h00200,
        DIV_SUB     = 17'h00400,
        DIV_RESTORE = 17'h00800,
        DIV_SETQ    = 17'h01000,
        DIV_CHECK   = 17'h02000,
        OUT_HI      = 17'h04000,
        OUT_LO      = 17'h08000,
        DONE        = 17'h10000
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state, nxt;
    logic [8:0]  a_reg, q_reg, m_reg;
    logic [2:0]  cnt;
    logic [1:0]  op;
    logic [7:0]  out_r;
    logic        end_r;
    logic [8:0]  sum, diff;

    assign sum  = a_reg + m_reg;
    assign diff = a_reg - m_reg;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:        nxt = bus.BEGIN ? LOAD_B : IDLE;
            LOAD_B: begin
                case (op)
                    OP_ADD:  nxt = ADD;
                    OP_SUB:  nxt = SUB;
                    OP_MUL:  nxt = MUL_TEST;
                    default: nxt = DIV_SHIFT;
                endcase
            end
            ADD, SUB:    nxt = OUT_LO;
            MUL_TEST: begin
                case (q_reg[1:0])
                    2'b01:   nxt = MUL_ADD;
                    2'b10:   nxt = MUL_SUB;
                    default: nxt = MUL_SHIFT;
                endcase
            end
            MUL_ADD, MUL_SUB: nxt = MUL_SHIFT;
            MUL_SHIFT:   nxt = MUL_CHECK;
            MUL_CHECK:   nxt = (cnt == 3'd7) ? OUT_HI : MUL_TEST;
            DIV_SHIFT:   nxt = DIV_SUB;
            // The branch looks at the sign of the difference being written this cycle.
            DIV_SUB:     nxt = diff[8] ? DIV_RESTORE : DIV_SETQ;
            DIV_RESTORE, DIV_SETQ: nxt = DIV_CHECK;
            DIV_CHECK:   nxt = (cnt == 3'd7) ? OUT_HI : DIV_SHIFT;
            OUT_HI:      nxt = OUT_LO;
            OUT_LO:      nxt = DONE;
            DONE:        nxt = bus.BEGIN ? DONE : IDLE;
            default:     nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
            op    <= '0;
            out_r <= '0;
            end_r <= 1'b0;
        end else begin
            state <= nxt;
            end_r <= 1'b0;
            case (state)
                IDLE: begin
                    out_r <= '0;
                    if (bus.BEGIN) begin
                        op <= bus.op_code;
                        if (bus.op_code[1]) begin
                            a_reg <= '0;
                            q_reg <= {bus.inbus, 1'b0};
                        end else begin
                            a_reg <= {bus.inbus[7], bus.inbus};
                            q_reg <= '0;
                        end
                    end
                end
                LOAD_B: begin
                    m_reg <= (op == OP_DIV) ? {1'b0, bus.inbus} : {bus.inbus[7], bus.inbus};
                    cnt   <= '0;
                end
                // Add/sub publish the new A directly, so the byte lands with END.
                ADD: begin
                    a_reg <= sum;
                    out_r <= sum[7:0];
                    end_r <= 1'b1;
                end
                SUB: begin
                    a_reg <= diff;
                    out_r <= diff[7:0];
                    end_r <= 1'b1;
                end
                MUL_ADD:     a_reg <= sum;
                MUL_SUB:     a_reg <= diff;
                MUL_SHIFT:   {a_reg, q_reg} <= {a_reg[8], a_reg, q_reg[8:1]};
                MUL_CHECK: begin
                    if (cnt == 3'd7) out_r <= a_reg[7:0];
                    else             cnt   <= cnt + 3'd1;
                end
                DIV_SHIFT: begin
                    a_reg <= {a_reg[7:0], q_reg[8]};
                    q_reg <= {q_reg[7:1], 1'b0, q_reg[0]};
                end
                DIV_SUB:     a_reg <= diff;
                DIV_RESTORE: begin
                    a_reg    <= sum;
                    q_reg[1] <= 1'b0;
                end
                DIV_SETQ:    q_reg[1] <= 1'b1;
                DIV_CHECK: begin
                    if (cnt == 3'd7) out_r <= q_reg[8:1];
                    else             cnt   <= cnt + 3'd1;
                end
                OUT_HI: begin
                    out_r <= (op == OP_MUL) ? q_reg[8:1] : a_reg[7:0];
                    end_r <= 1'b1;
                end
                DONE: if (!bus.BEGIN) out_r <= '0;
                default: ;
            endcase
        end
    end

    assign bus.outbus       = out_r;
    assign bus.END          = end_r;
    assign act_state_debug  = state;
    assign next_state_debug = nxt;
    assign A_reg_debug      = a_reg;
    assign Q_reg_debug      = q_reg;
    assign M_reg_debug      = m_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed spec vectors, random back-to-back
// operations against an arithmetic model, abort and held-BEGIN scenarios.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if bus();
    logic [16:0] act_s, nxt_s;
    logic [8:0]  a_d, q_d, m_d;

    alu_seq dut (
        .clk(clk), .reset(reset), .bus(bus),
        .act_state_debug(act_s), .next_state_debug(nxt_s),
        .A_reg_debug(a_d), .Q_reg_debug(q_d), .M_reg_debug(m_d)
    );

    int errors = 0;
    int checks = 0;

    // Expected result bytes and END cycle (cycle 1 = the cycle after the start edge).
    function automatic void model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] hi, output logic [7:0] lo, output int lat);
        logic signed [15:0] p;
        int t;
        hi = 8'h00; lo = 8'h00; lat = 3;
        case (op)
            2'b00: lo = 8'(x + y);
            2'b01: lo = 8'(x - y);
            2'b10: begin
                p  = 16'(signed'(x)) * 16'(signed'(y));
                hi = p[15:8];
                lo = p[7:0];
                t  = 0;
                for (int i = 0; i < 8; i++)
                    if (x[i] != ((i == 0) ? 1'b0 : x[i-1])) t++;
                lat = 27 + t;
            end
            default: begin
                if (y == 8'h00) begin hi = 8'hFF; lo = x; end
                else begin hi = x / y; lo = x % y; end
                lat = 35;
            end
        endcase
    endfunction

    // Runs one operation and reports what the DUT did; returns at END+2.
    task automatic do_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic hold, output logic [7:0] hi, output logic [7:0] lo,
                         output int end_cyc, output int n_end, output logic timeout,
                         output int bad_oh);
        int cyc;
        logic [7:0] prev;
        bus.BEGIN = 1'b1; bus.op_code = op; bus.inbus = x;
        @(posedge clk); #1;
        bus.BEGIN = hold; bus.inbus = y;
        cyc = 1; prev = bus.outbus; n_end = 0; end_cyc = -1;
        hi = 8'h00; lo = 8'h00; timeout = 1'b1; bad_oh = 0;
        while (cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if ($countones(act_s) != 1) bad_oh++;
            if (bus.END === 1'b1) begin
                n_end++;
                if (n_end == 1) begin end_cyc = cyc; lo = bus.outbus; hi = prev; end
            end
            prev = bus.outbus;
            if (end_cyc > 0 && cyc == end_cyc + 2) begin timeout = 1'b0; break; end
        end
        if (timeout) begin
            bus.BEGIN = 1'b0; reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.BEGIN = 1'b0; bus.op_code = 2'b00; bus.inbus = 8'h00;
        @(posedge clk); #1;
        checks++; if (act_s !== 17'h00001) begin errors++; $display("FAIL reset_state got %h want %h", act_s, 17'h00001); end
        checks++; if (bus.outbus !== 8'h00 || bus.END !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b want 00/0", bus.outbus, bus.END); end
        checks++; if (a_d !== 9'h0 || q_d !== 9'h0 || m_d !== 9'h0) begin errors++; $display("FAIL reset_regs got %h %h %h want 0 0 0", a_d, q_d, m_d); end
        reset = 1'b0;
        bus.BEGIN = 1'b1; #1;
        checks++; if (nxt_s !== 17'h00002) begin errors++; $display("FAIL idle_next got %h want %h", nxt_s, 17'h00002); end
        bus.BEGIN = 1'b0;
        @(posedge clk); #1;
    endtask

    // Directed vectors: {op, x, y, expected hi, expected lo, expected END cycle}
    task automatic test_directed(input string name, input logic [1:0] op, input logic [7:0] x,
                                 input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo,
                                 input int elat);
        logic [7:0] hi, lo; int ec, ne, boh; logic to;
        do_op(op, x, y, 1'b0, hi, lo, ec, ne, to, boh);
        checks++; if (to !== 1'b0 || ne !== 1) begin errors++; $display("FAIL %s_end got timeout=%b ends=%0d want 0/1", name, to, ne); end
        checks++; if (lo !== elo) begin errors++; $display("FAIL %s_lo got %h want %h", name, lo, elo); end
        if (op[1]) begin
            checks++; if (hi !== ehi) begin errors++; $display("FAIL %s_hi got %h want %h", name, hi, ehi); end
        end
        checks++; if (ec !== elat) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, ec, elat); end
        checks++; if (act_s !== 17'h00001 || bus.outbus !== 8'h00 || boh !== 0) begin errors++; $display("FAIL %s_idle got state=%h out=%h badoh=%0d want 00001/00/0", name, act_s, bus.outbus, boh); end
    endtask

    task automatic test_add();
        test_directed("add", 2'b00, 8'd56, 8'd89, 8'h00, 8'h91, 3);
        test_directed("add_wrap", 2'b00, 8'd200, 8'd100, 8'h00, 8'h2C, 3);
    endtask

    task automatic test_sub();
        test_directed("sub", 2'b01, 8'd56, 8'd89, 8'h00, 8'hDF, 3);
        test_directed("sub_pos", 2'b01, 8'd89, 8'd56, 8'h00, 8'h21, 3);
    endtask

    task automatic test_mul();
        // 56 = 0011_1000 has 2 Booth transitions; FD = 1111_1101 has 3
        test_directed("mul", 2'b10, 8'd56, 8'd89, 8'h13, 8'h78, 29);
        test_directed("mul_neg", 2'b10, 8'hFD, 8'h07, 8'hFF, 8'hEB, 30);
    endtask

    task automatic test_div();
        test_directed("div", 2'b11, 8'd200, 8'd7, 8'd28, 8'd4, 35);
        test_directed("div_small", 2'b11, 8'd56, 8'd89, 8'd0, 8'd56, 35);
        test_directed("div_zero", 2'b11, 8'd77, 8'd0, 8'hFF, 8'd77, 35);
    endtask

    task automatic test_back_to_back();
        logic [7:0] hi, lo, ehi, elo; int ec, ne, boh, elat; logic to;
        logic [1:0] op; logic [7:0] x, y;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            x  = 8'($urandom);
            y  = (n % 10 == 9) ? 8'h00 : 8'($urandom);
            model(op, x, y, ehi, elo, elat);
            do_op(op, x, y, 1'b0, hi, lo, ec, ne, to, boh);
            checks++;
            if (to !== 1'b0 || ne !== 1 || lo !== elo || (op[1] && hi !== ehi) || ec !== elat || boh !== 0) begin
                errors++;
                $display("FAIL rand op=%0d x=%h y=%h got hi=%h lo=%h lat=%0d ends=%0d to=%b badoh=%0d want hi=%h lo=%h lat=%0d",
                         op, x, y, hi, lo, ec, ne, to, boh, ehi, elo, elat);
            end
        end
    endtask

    task automatic test_abort();
        int ends, waited;
        ends = 0; waited = 0;
        bus.BEGIN = 1'b1; bus.op_code = 2'b10; bus.inbus = 8'd56;
        @(posedge clk); #1;
        bus.BEGIN = 1'b0; bus.inbus = 8'd89;
        while (act_s !== 17'h00010 && waited < 10) begin
            @(posedge clk); #1; waited++;
            if (bus.END === 1'b1) ends++;
        end
        checks++; if (act_s !== 17'h00010) begin errors++; $display("FAIL abort_reach got %h want %h", act_s, 17'h00010); end
        checks++; if (bus.outbus !== 8'h00) begin errors++; $display("FAIL abort_compute_out got %h want 00", bus.outbus); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (act_s !== 17'h00001 || a_d !== 9'h0 || q_d !== 9'h0 || m_d !== 9'h0) begin errors++; $display("FAIL abort_state got %h %h %h %h want 00001 0 0 0", act_s, a_d, q_d, m_d); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.END === 1'b1 || act_s !== 17'h00001) ends++;
        end
        checks++; if (ends !== 0) begin errors++; $display("FAIL abort_no_end got %0d events want 0", ends); end
    endtask

    task automatic test_hold_begin();
        logic [7:0] hi, lo; int ec, ne, boh, bad; logic to;
        do_op(2'b00, 8'd10, 8'd20, 1'b1, hi, lo, ec, ne, to, boh);
        checks++; if (to !== 1'b0 || ne !== 1 || lo !== 8'd30) begin errors++; $display("FAIL hold_result got lo=%h ends=%0d to=%b want 1e/1/0", lo, ne, to); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (act_s !== 17'h10000 || bus.outbus !== 8'd30 || bus.END !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_done got %0d bad cycles want 0 (state=%h)", bad, act_s); end
        bus.BEGIN = 1'b0;
        @(posedge clk); #1;
        checks++; if (act_s !== 17'h00001 || bus.outbus !== 8'h00) begin errors++; $display("FAIL hold_release got %h/%h want 00001/00", act_s, bus.outbus); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_abort();
        test_hold_begin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential 8-bit ALU with a single shared 8-bit input bus and an 8-bit output bus.
- Supports add, subtract, signed multiply (Booth radix-2) and unsigned divide (restoring).
- Control is a 17-state one-hot FSM driving 9-bit registers A, Q and M.
- A BEGIN/END handshake frames each operation; debug ports expose the FSM state and the datapath registers.

Parameters:
- None. Widths are fixed: 8-bit data, 9-bit registers, 17-bit state, 3-bit iteration counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- BEGIN  in  1  start request, sampled in IDLE
- op_code  in  2  00 add, 01 sub, 10 mul, 11 div; latched on start
- inbus  in  8  operand input bus
- outbus  out  8  result output bus
- END  out  1  one-cycle pulse marking the final result byte
- act_state_debug  out  17  current one-hot state
- next_state_debug  out  17  combinational next one-hot state
- A_reg_debug  out  9  register A
- Q_reg_debug  out  9  register Q; Q[8:1] is the operand/result and Q[0] is the Booth Q-1 bit
- M_reg_debug  out  9  register M

Behaviour:
- State bit indices:
  - 0 IDLE, 1 LOAD_B, 2 ADD, 3 SUB
  - 4 MUL_TEST, 5 MUL_ADD, 6 MUL_SUB, 7 MUL_SHIFT, 8 MUL_CHECK
  - 9 DIV_SHIFT, 10 DIV_SUB, 11 DIV_RESTORE, 12 DIV_SETQ, 13 DIV_CHECK
  - 14 OUT_HI, 15 OUT_LO, 16 DONE
- Reset: state = IDLE (17'h00001); A, Q, M, counter and latched op all 0; outbus = 0; END = 0. Reset mid-operation aborts immediately to IDLE with no END.
- IDLE:
  - If BEGIN=1, latch op_code and load operand X = inbus, then go to LOAD_B.
  - add/sub: A = sign-extended X, Q = 0.
  - mul/div: A = 0, Q = {X, 1'b0}.
  - If BEGIN=0, stay in IDLE.
- LOAD_B:
  - Load M from inbus: zero-extended for div, sign-extended otherwise. Clear the counter.
  - Next state: ADD, SUB, MUL_TEST or DIV_SHIFT according to op.
- ADD: A = A + M. SUB: A = A - M. Both go to OUT_LO. Result is A[7:0], taken modulo 256.
- Multiply (Booth), 8 iterations:
  - MUL_TEST branches on Q[1:0]: 01 → MUL_ADD, 10 → MUL_SUB, 00/11 → MUL_SHIFT.
  - MUL_ADD: A = A + M. MUL_SUB: A = A - M. Both go to MUL_SHIFT.
  - MUL_SHIFT: arithmetic right shift of the 18-bit {A,Q}.
  - MUL_CHECK: if counter == 7 → OUT_HI; else counter++ and go to MUL_TEST.
  - Product = {A[7:0], Q[8:1]} as a signed 16-bit value.
- Divide (restoring, unsigned), 8 iterations:
  - DIV_SHIFT: {A,Q[8:1]} shifted left by 1.
  - DIV_SUB: A = A - M. If A[8]=1 → DIV_RESTORE, else → DIV_SETQ.
  - DIV_RESTORE: A = A + M and Q[1] = 0. DIV_SETQ: Q[1] = 1. Both go to DIV_CHECK.
  - DIV_CHECK: same counter rule as MUL_CHECK, going to OUT_HI or DIV_SHIFT.
  - Quotient = Q[8:1]; remainder = A[7:0].
  - Divide by zero: quotient = 8'hFF, remainder = dividend. No error flag.
- OUT_HI (1 cycle):
  - outbus = mul: A[7:0] (product high byte); div: Q[8:1] (quotient).
  - END = 0. Next state is OUT_LO.
- OUT_LO (1 cycle):
  - outbus = add/sub: A[7:0]; mul: Q[8:1] (product low byte); div: A[7:0] (remainder).
  - END = 1. Next state is DONE.
- DONE: END = 0 and outbus holds the last byte. Return to IDLE once BEGIN=0; stay in DONE while BEGIN=1, so a held BEGIN does not retrigger.
- Output rules:
  - outbus is registered; it is 0 in IDLE, LOAD_B and the compute states.
  - END is high in exactly one cycle per operation.
- Latency for add/sub, counted from the start edge: END is high during the 3rd cycle after it.
- Mul/div run 8 iterations; END follows OUT_HI.
- The next operation may start the cycle after returning to IDLE.
- act_state_debug is always one-hot.

Test Plan:
- Reset: reset=1 for 1 edge → act_state_debug=17'h00001, outbus=0, END=0.
- Add: BEGIN=1, op=00, inbus=56 on one edge; then BEGIN=0, inbus=89 → END pulse with outbus=8'h91 (145). Repeat with 200+100 → 8'h2C (wrap-around).
- Sub: 56 then 89, op=01 → END with outbus=8'hDF (−33). Also 89−56 → 8'h21.
- Mul: 56 then 89, op=10 → OUT_HI byte 8'h13, then END with byte 8'h78 (4984). Also (−3)×7 = 8'hFD × 8'h07 → 8'hFF then 8'hEB.
- Div: 200 then 7, op=11 → OUT_HI byte 28, then END with byte 4. Also 56/89 → 0, then 56. Also 77/0 → 8'hFF, then 77.
- Abort and retrigger: assert reset during MUL_TEST → IDLE with no END. Hold BEGIN=1 through END → FSM stays in DONE until BEGIN falls.
